// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: decodes one RV32IM ALU/branch/store instruction,
// presents registered operands to an external ALU, and holds the result until consumed.
module alu_issue_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [3:0]  op_code,
  output logic [1:0]  irmux,
  output logic [31:0] alu_a,
  output logic [31:0] alu_rs2,
  output logic [31:0] imm_s,
  output logic [31:0] imm_i,
  input  logic [31:0] alu_out,
  input  logic        bt,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_we,
  output logic        res_branch,
  output logic        illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] mux;
    logic       we;
    logic       br;
    logic       br_inv;
    logic       bad;
  } dec_t;

  localparam dec_t DEC_IDLE = '{op: 4'b0000, mux: 2'b10, we: 1'b0, br: 1'b0, br_inv: 1'b0, bad: 1'b0};
  localparam dec_t DEC_BAD  = '{op: 4'b0000, mux: 2'b10, we: 1'b0, br: 1'b0, br_inv: 1'b0, bad: 1'b1};

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = 4'b0000;
      3'b001:  base_op = 4'b1001;
      3'b010:  base_op = 4'b1100;
      3'b011:  base_op = 4'b1101;
      3'b100:  base_op = 4'b1000;
      3'b101:  base_op = 4'b1010;
      3'b110:  base_op = 4'b0111;
      default: base_op = 4'b0110;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] iw);
    dec_t       d;
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = iw[14:12];
    f7 = iw[31:25];
    d  = DEC_IDLE;
    ok = 1'b0;
    case (iw[6:0])
      OPC_OP: begin
        d.we = 1'b1;
        case (f7)
          7'b0000000: begin
            ok   = 1'b1;
            d.op = base_op(f3);
          end
          7'b0100000: begin
            ok   = (f3 == 3'b000) || (f3 == 3'b101);
            d.op = (f3 == 3'b000) ? 4'b0001 : 4'b1011;
          end
          7'b0000001: begin
            ok = 1'b1;
            case (f3)
              3'b000:  d.op = 4'b0011;
              3'b001:  d.op = 4'b0010;
              3'b100:  d.op = 4'b0100;
              3'b110:  d.op = 4'b0101;
              default: ok = 1'b0;
            endcase
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_IMM: begin
        d.we  = 1'b1;
        d.mux = 2'b01;
        d.op  = base_op(f3);
        case (f3)
          3'b001: ok = (f7 == 7'b0000000);
          3'b101: begin
            ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            if (iw[30]) d.op = 4'b1011;
          end
          default: ok = 1'b1;
        endcase
      end
      OPC_BR: begin
        // funct3[0] selects the inverted sense (BNE/BGE/BGEU)
        d.br     = 1'b1;
        d.br_inv = f3[0];
        ok       = (f3[2:1] != 2'b01);
        d.op     = !f3[2] ? 4'b1110 : (f3[1] ? 4'b1101 : 4'b1100);
      end
      OPC_ST: begin
        d.mux = 2'b00;
        ok    = !f3[2] && (f3[1:0] != 2'b11);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) d = DEC_BAD;
    return d;
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    is_md = (op == 4'b0011) || (op == 4'b0010) || (op == 4'b0100) || (op == 4'b0101);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dec_t        dec_q, dec_d, dec_in;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_i_q, imm_i_d, imm_s_q, imm_s_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_branch_q, res_branch_d;
  logic        shamt_fmt;

  assign dec_in    = decode(instr);
  assign shamt_fmt = (instr[6:0] == OPC_IMM) && (instr[13:12] == 2'b01);
  assign in_ready  = (state_q == S_IDLE) && rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_d        = dec_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    imm_i_d      = imm_i_q;
    imm_s_d      = imm_s_q;
    rd_d         = rd_q;
    res_data_d   = res_data_q;
    res_branch_d = res_branch_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          dec_d        = dec_in;
          rs1_d        = rs1_val;
          rs2_d        = rs2_val;
          imm_i_d      = shamt_fmt ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
          imm_s_d      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          rd_d         = dec_in.we ? instr[11:7] : 5'd0;
          res_data_d   = 32'd0;
          res_branch_d = 1'b0;
          cnt_d        = is_md(dec_in.op) ? MD_LOAD : 4'd0;
          state_d      = dec_in.bad ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_data_d   = alu_out;
          res_branch_d = dec_q.br & (bt ^ dec_q.br_inv);
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      dec_q        <= DEC_IDLE;
      rs1_q        <= 32'd0;
      rs2_q        <= 32'd0;
      imm_i_q      <= 32'd0;
      imm_s_q      <= 32'd0;
      rd_q         <= 5'd0;
      res_data_q   <= 32'd0;
      res_branch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      imm_i_q      <= imm_i_d;
      imm_s_q      <= imm_s_d;
      rd_q         <= rd_d;
      res_data_q   <= res_data_d;
      res_branch_q <= res_branch_d;
    end
  end

  assign op_code    = dec_q.op;
  assign irmux      = dec_q.mux;
  assign alu_a      = rs1_q;
  assign alu_rs2    = rs2_q;
  assign imm_i      = imm_i_q;
  assign imm_s      = imm_s_q;
  assign res_valid  = (state_q == S_DONE);
  assign res_data   = res_data_q;
  assign res_rd     = rd_q;
  assign res_we     = dec_q.we;
  assign res_branch = res_branch_q;
  assign illegal    = dec_q.bad;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU driving alu_out/bt.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [3:0]  op_code;
  logic [1:0]  irmux;
  logic [31:0] alu_a;
  logic [31:0] alu_rs2;
  logic [31:0] imm_s;
  logic [31:0] imm_i;
  logic [31:0] alu_out;
  logic        bt;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we;
  logic        res_branch;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .op_code(op_code), .irmux(irmux), .alu_a(alu_a), .alu_rs2(alu_rs2),
    .imm_s(imm_s), .imm_i(imm_i), .alu_out(alu_out), .bt(bt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_we(res_we), .res_branch(res_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU: only the operations the directed vectors exercise
  logic [31:0] opb;
  always_comb begin
    opb = (irmux == 2'b00) ? imm_s : (irmux == 2'b01) ? imm_i : alu_rs2;
    case (op_code)
      4'b0000: alu_out = alu_a + opb;
      4'b0001: alu_out = alu_a - opb;
      4'b0011: alu_out = alu_a * opb;
      4'b0100: alu_out = (opb != 0) ? 32'($signed(alu_a) / $signed(opb)) : 32'hFFFFFFFF;
      4'b1011: alu_out = 32'($signed(alu_a) >>> opb[4:0]);
      4'b1110: alu_out = {31'b0, alu_a == opb};
      default: alu_out = 32'd0;
    endcase
    bt = alu_out[0];
  end

  task automatic issue(input logic [31:0] iw, input logic [31:0] a, input logic [31:0] b);
    instr    = iw;
    rs1_val  = a;
    rs2_val  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic retire;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, res_valid, illegal, res_we, res_branch} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 00000", {in_ready, res_valid, illegal, res_we, res_branch});
    end
    checks++;
    if ({op_code, irmux, res_rd} !== {4'b0000, 2'b10, 5'd0}) begin
      errors++; $display("FAIL reset_dec: got %h required %h", {op_code, irmux, res_rd}, {4'b0000, 2'b10, 5'd0});
    end
    checks++;
    if ({res_data, alu_a, alu_rs2, imm_i, imm_s} !== 160'd0) begin
      errors++; $display("FAIL reset_data: got %h required 0", {res_data, alu_a, alu_rs2, imm_i, imm_s});
    end
    in_valid = 1'b0; rst = 1'b1; #1;
    checks++;
    if ({in_ready, res_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release: got %b required 10", {in_ready, res_valid});
    end
  endtask

  task automatic test_add;
    int n;
    issue(32'h002081B3, 32'd5, 32'd7);
    checks++;
    if ({op_code, irmux, res_valid, in_ready} !== {4'b0000, 2'b10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_dec: got %b required 0000_10_0_0", {op_code, irmux, res_valid, in_ready});
    end
    wait_valid(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL add_latency: got %0d required 1", n); end
    checks++;
    if ({res_data, res_rd, res_we, res_branch, illegal} !== {32'd12, 5'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_result: data=%0d rd=%0d we=%b br=%b ill=%b required 12 3 1 0 0",
                         res_data, res_rd, res_we, res_branch, illegal);
    end
    retire();
  endtask

  task automatic test_op_imm;
    int n;
    issue(32'hFFF00093, 32'd0, 32'd99);
    checks++;
    if ({op_code, irmux, imm_i} !== {4'b0000, 2'b01, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL addi_dec: op=%b mux=%b imm_i=%h required 0000 01 ffffffff", op_code, irmux, imm_i);
    end
    wait_valid(n);
    checks++;
    if ({n[3:0], res_data, res_rd, res_we} !== {4'd1, 32'hFFFFFFFF, 5'd1, 1'b1}) begin
      errors++; $display("FAIL addi_result: n=%0d data=%h rd=%0d we=%b required 1 ffffffff 1 1", n, res_data, res_rd, res_we);
    end
    retire();
    issue(32'h40415113, 32'h80000000, 32'd0);
    checks++;
    if ({op_code, irmux, imm_i} !== {4'b1011, 2'b01, 32'h00000004}) begin
      errors++; $display("FAIL srai_dec: op=%b mux=%b imm_i=%h required 1011 01 00000004", op_code, irmux, imm_i);
    end
    wait_valid(n);
    checks++;
    if ({res_data, res_rd} !== {32'hF8000000, 5'd2}) begin
      errors++; $display("FAIL srai_result: data=%h rd=%0d required f8000000 2", res_data, res_rd);
    end
    retire();
  endtask

  task automatic test_mul;
    issue(32'h027302B3, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({res_valid, op_code, alu_a, alu_rs2} !== {1'b0, 4'b0011, 32'd6, 32'd7}) begin
        errors++; $display("FAIL mul_exec_%0d: vld=%b op=%b a=%0d b=%0d required 0 0011 6 7", i, res_valid, op_code, alu_a, alu_rs2);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({res_valid, res_data, res_rd, res_we} !== {1'b1, 32'd42, 5'd5, 1'b1}) begin
      errors++; $display("FAIL mul_result: vld=%b data=%0d rd=%0d we=%b required 1 42 5 1", res_valid, res_data, res_rd, res_we);
    end
    retire();
  endtask

  task automatic test_branch;
    int n;
    issue(32'h00209063, 32'd9, 32'd9);
    checks++;
    if ({op_code, irmux} !== {4'b1110, 2'b10}) begin
      errors++; $display("FAIL bne_dec: op=%b mux=%b required 1110 10", op_code, irmux);
    end
    wait_valid(n);
    checks++;
    if ({res_branch, res_we, res_rd} !== {1'b0, 1'b0, 5'd0}) begin
      errors++; $display("FAIL bne_result: br=%b we=%b rd=%0d required 0 0 0", res_branch, res_we, res_rd);
    end
    retire();
    issue(32'h00208063, 32'd9, 32'd9);
    wait_valid(n);
    checks++;
    if ({res_branch, res_we, res_rd} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL beq_result: br=%b we=%b rd=%0d required 1 0 0", res_branch, res_we, res_rd);
    end
    retire();
  endtask

  task automatic test_store;
    int n;
    issue(32'hFE20AE23, 32'h100, 32'h55);
    checks++;
    if ({op_code, irmux, imm_s} !== {4'b0000, 2'b00, 32'hFFFFFFFC}) begin
      errors++; $display("FAIL sw_dec: op=%b mux=%b imm_s=%h required 0000 00 fffffffc", op_code, irmux, imm_s);
    end
    wait_valid(n);
    checks++;
    if ({res_valid, res_we, res_rd, illegal} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL sw_result: vld=%b we=%b rd=%0d ill=%b required 1 0 0 0", res_valid, res_we, res_rd, illegal);
    end
    retire();
  endtask

  task automatic test_illegal;
    int n;
    issue(32'hFFFFFFFF, 32'd1, 32'd2);
    wait_valid(n);
    checks++;
    if ({n[3:0], illegal, res_data, res_we, res_rd} !== {4'd0, 1'b1, 32'd0, 1'b0, 5'd0}) begin
      errors++; $display("FAIL illegal_result: n=%0d ill=%b data=%h we=%b rd=%0d required 0 1 0 0 0",
                         n, illegal, res_data, res_we, res_rd);
    end
    retire();
  endtask

  task automatic test_back_to_back;
    int n;
    issue(32'h002081B3, 32'd100, 32'd23);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid, in_ready, res_data, res_rd, res_we, illegal} !== {1'b1, 1'b0, 32'd123, 5'd3, 1'b1, 1'b0}) begin
        errors++; $display("FAIL hold_%0d: vld=%b rdy=%b data=%0d rd=%0d we=%b ill=%b required 1 0 123 3 1 0",
                           i, res_valid, in_ready, res_data, res_rd, res_we, illegal);
      end
      @(posedge clk); #1;
    end
    instr = 32'h002081B3; rs1_val = 32'd1; rs2_val = 32'd2; in_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if ({res_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL release_idle: vld=%b rdy=%b required 0 1", res_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if ({n[3:0], res_data} !== {4'd1, 32'd3}) begin
      errors++; $display("FAIL back_to_back: n=%0d data=%0d required 1 3", n, res_data);
    end
    retire();
  endtask

  task automatic test_div_reset;
    int n;
    issue(32'h023140B3, 32'd20, 32'd3);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({res_valid, op_code} !== {1'b0, 4'b0100}) begin
      errors++; $display("FAIL div_exec: vld=%b op=%b required 0 0100", res_valid, op_code);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({res_valid, in_ready, op_code, irmux} !== {1'b0, 1'b0, 4'b0000, 2'b10}) begin
      errors++; $display("FAIL div_reset: vld=%b rdy=%b op=%b mux=%b required 0 0 0000 10", res_valid, in_ready, op_code, irmux);
    end
    rst = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL div_reset_idle: rdy=%b required 1", in_ready); end
    issue(32'h002081B3, 32'd5, 32'd7);
    wait_valid(n);
    checks++;
    if ({n[3:0], res_data} !== {4'd1, 32'd12}) begin
      errors++; $display("FAIL post_reset_add: n=%0d data=%0d required 1 12", n, res_data);
    end
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
    test_reset();
    test_add();
    test_op_imm();
    test_mul();
    test_branch();
    test_store();
    test_illegal();
    test_back_to_back();
    test_div_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter MD_LAT, default 4, meaning the number of EXEC cycles for multiply/divide ops (legal range 1..15).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction can be accepted
- instr  in  32  RV32 instruction word
- rs1_val  in  32  source operand 1
- rs2_val  in  32  source operand 2
- op_code  out  4  ALU operation select
- irmux  out  2  ALU B select: 00=imm_s, 01=imm_i, 10=rs2
- alu_a  out  32  ALU A operand
- alu_rs2  out  32  ALU rs2 operand
- imm_s  out  32  S-type immediate
- imm_i  out  32  I-type immediate
- alu_out  in  32  ALU result
- bt  in  1  ALU branch-taken bit (alu_out[0])
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  32  captured result
- res_rd  out  5  destination register
- res_we  out  1  register write enable
- res_branch  out  1  branch resolved taken
- illegal  out  1  instruction not decodable

Function
REQ-003 The FSM SHALL have states IDLE, EXEC, DONE; in_ready SHALL be 1 only in IDLE with rst high.
REQ-004 On in_valid&in_ready, the block SHALL register instr, rs1_val, and rs2_val, and SHALL enter EXEC (legal) or DONE (illegal, res_data=0, illegal=1, res_we=0).
REQ-005 op_code, irmux, alu_a, alu_rs2, imm_s, and imm_i SHALL be driven only from registered state and SHALL be stable for the whole of EXEC.
REQ-006 OP (0110011) decode SHALL be, by funct7/funct3:
- 0000000: ADD 000->0000; SLL 001->1001; SLT 010->1100; SLTU 011->1101; XOR 100->1000; SRL 101->1010; OR 110->0111; AND 111->0110
- 0100000: SUB 000->0001; SRA 101->1011
- 0000001: MUL 000->0011; MULH 001->0010; DIV 100->0100; REM 110->0101
- irmux=10 for all OP ops
REQ-007 OP-IMM (0010011) SHALL use the same funct3 mapping with irmux=01.
- imm_i SHALL be sign-extended instr[31:20].
- For SLLI/SRLI/SRAI, imm_i SHALL be zero-extended instr[24:20]; SRAI SHALL be identified by instr[30]=1 and SHALL map to 1011.
REQ-008 BRANCH (1100011) SHALL map BEQ/BNE->1110, BLT/BGE->1100, BLTU/BGEU->1101, irmux=10; res_branch SHALL be bt for BEQ/BLT/BLTU and ~bt for BNE/BGE/BGEU; res_we=0.
REQ-009 STORE (0100011) SHALL map to op 0000 with irmux=00; imm_s SHALL be sign-extended {instr[31:25],instr[11:7]}; res_we=0 and res_rd=0.
REQ-010 Any other opcode, funct7, or funct3 combination SHALL be illegal.
REQ-011 EXEC length SHALL be 1 cycle for non-M ops and MD_LAT cycles for MUL/MULH/DIV/REM, using a down-counter loaded at accept.
- alu_out SHALL be captured into res_data on the final EXEC edge, followed by a transition to DONE.
REQ-012 res_valid SHALL be 1 exactly in DONE; res_data, res_rd, res_we, res_branch, and illegal SHALL hold constant while res_valid=1 and res_ready=0.
REQ-013 DONE SHALL go to IDLE on res_ready=1; no new instruction SHALL be accepted in the same cycle (minimum 3 cycles per instruction).
REQ-014 res_rd SHALL be instr[11:7] and res_we=1 for OP/OP-IMM; res_rd=0 when res_we=0. A write to rd=0 SHALL still report res_we=1.

Reset
REQ-015 While rst=0 at a clock edge, the state SHALL become IDLE, the counter SHALL be 0, and all outputs SHALL become 0 except irmux=10; in_ready SHALL be 0 while rst=0.
REQ-016 Reset asserted in EXEC or DONE SHALL discard the in-flight instruction; res_valid SHALL be 0 from the next edge.

Verification
REQ-017 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, alu_out model=12 -> op_code=0000, irmux=10, res_valid high 1 edge after accept, res_data=12, res_rd=3, res_we=1.
REQ-018 ADDI x1,x0,-1 (0xFFF00093) -> irmux=01, imm_i=0xFFFFFFFF; SRAI x2,x2,4 (0x40415113) -> op_code=1011, imm_i=0x00000004.
REQ-019 MUL x5,x6,x7 (0x027302B3) with MD_LAT=4 -> op_code=0011, operands stable for 4 cycles, res_valid first high 4 edges after accept.
REQ-020 BNE with bt=1 -> res_branch=0, res_we=0, res_rd=0; BEQ with bt=1 -> res_branch=1.
REQ-021 res_ready held 0 for 5 cycles in DONE -> res_* stable, in_ready=0; res_ready=1 -> IDLE next edge, in_ready=1.
REQ-022 Illegal instruction 0xFFFFFFFF -> illegal=1, res_data=0; rst=0 mid-EXEC of DIV -> res_valid=0 and IDLE after the next edge.
